// File: rtl/b64_job_sched.sv
// rtl/b64_job_sched.sv - round-robin scheduler sharing one 60-byte base64 encode core among NREQ requesters
// Optional job/busy statistics outputs are enabled by defining B64_SCHED_STATS_EN.
module b64_job_sched #(
  parameter int NREQ     = 2,
  parameter int CORE_LAT = 2,
  parameter int IDW      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*480-1:0]  req_data,
  input  logic [NREQ*6-1:0]    req_nbytes,
  output logic [479:0]         core_data,
  output logic                 core_start,
  input  logic [639:0]         core_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [639:0]         rsp_data,
  output logic [6:0]           rsp_nchars
`ifdef B64_SCHED_STATS_EN
  ,
  output logic [31:0]          stat_jobs,
  output logic [31:0]          stat_busy
`endif
);

  localparam int IXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(CORE_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state;
  logic [IXW-1:0]  rr;
  logic [IXW-1:0]  gidx;
  logic            found;
  logic [NREQ-1:0] grant;
  logic [5:0]      sel_nb;
  logic [5:0]      n_clamp;
  logic [5:0]      n_q;
  logic [479:0]    sel_data;
  logic [479:0]    mdata;
  logic [CW-1:0]   cnt;
  logic [5:0]      grp;
  logic [1:0]      rem;
  logic [6:0]      nch;
  logic [639:0]    pad_data;

  // First valid requester at or after the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    grant = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && req_valid[(int'(rr) + off) % NREQ]) begin
        found = 1'b1;
        gidx  = IXW'((int'(rr) + off) % NREQ);
      end
    end
    if (state == IDLE && found && rst_n)
      grant[gidx] = 1'b1;
  end

  assign req_ready = grant;

  always_comb begin
    sel_data = req_data[480*int'(gidx) +: 480];
    sel_nb   = req_nbytes[6*int'(gidx) +: 6];
    n_clamp  = (sel_nb > 6'd60) ? 6'd60 : sel_nb;
    mdata    = '0;
    for (int k = 0; k < 60; k++) begin
      if (k < int'(n_clamp))
        mdata[479-8*k -: 8] = sel_data[479-8*k -: 8];
    end
  end

  // Characters past the last group are zeroed; partial groups end in '='.
  always_comb begin
    grp      = (n_q + 6'd2) / 6'd3;
    rem      = 2'(n_q % 6'd3);
    nch      = 7'({grp, 2'b00});
    pad_data = '0;
    for (int j = 0; j < 80; j++) begin
      if (j < int'(nch)) begin
        if ((rem == 2'd1 && j >= int'(nch) - 2) || (rem == 2'd2 && j == int'(nch) - 1))
          pad_data[639-8*j -: 8] = 8'h3D;
        else
          pad_data[639-8*j -: 8] = core_result[639-8*j -: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr         <= '0;
      n_q        <= '0;
      cnt        <= '0;
      core_start <= 1'b0;
      core_data  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_nchars <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            rsp_id    <= IDW'(gidx);
            n_q       <= n_clamp;
            core_data <= mdata;
            rr        <= (gidx == IXW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            if (n_clamp == 6'd0) begin
              rsp_data   <= '0;
              rsp_nchars <= '0;
              rsp_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              core_start <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          core_start <= 1'b0;
          cnt        <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (cnt == CW'(CORE_LAT - 1)) begin
            rsp_data   <= pad_data;
            rsp_nchars <= nch;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef B64_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_jobs <= '0;
      stat_busy <= '0;
    end else begin
      if (state == DONE && rsp_ready)
        stat_jobs <= stat_jobs + 32'd1;
      if (state != IDLE && stat_busy != 32'hFFFF_FFFF)
        stat_busy <= stat_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_b64_job_sched.sv
// tb/tb_b64_job_sched.sv - scoreboard bench for b64_job_sched with a base64 core model
module tb_b64_job_sched;
  localparam int NREQ = 2;
  localparam int LAT  = 2;
  localparam int IDW  = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*480-1:0] req_data;
  logic [NREQ*6-1:0]   req_nbytes;
  logic [479:0]        core_data;
  logic                core_start;
  logic [639:0]        core_result;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [639:0]        rsp_data;
  logic [6:0]          rsp_nchars;
`ifdef B64_SCHED_STATS_EN
  logic [31:0]         stat_jobs;
  logic [31:0]         stat_busy;
`endif

  b64_job_sched #(.NREQ(NREQ), .CORE_LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_nbytes(req_nbytes),
    .core_data(core_data), .core_start(core_start), .core_result(core_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_nchars(rsp_nchars)
`ifdef B64_SCHED_STATS_EN
    , .stat_jobs(stat_jobs), .stat_busy(stat_busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [639:0]   data;
    logic [6:0]     nch;
    int             t_acc;
    int             lat;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           rr_m = 0;
  int           starts_exp = 0;
  int           starts_seen = 0;
  bit           accepted [NREQ];
  bit           lit_on = 1'b0;
  logic [639:0] lit_data;
  logic [6:0]   lit_nch;
  string        alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Textbook base64 of the first min(nb,60) bytes, '=' padded, rest zero.
  function automatic void b64_ref(input logic [479:0] blk, input int nb,
                                  output logic [639:0] d, output logic [6:0] nch);
    int n;
    int oc;
    int rem;
    logic [7:0] b [60];
    logic [23:0] v;
    n  = (nb > 60) ? 60 : nb;
    d  = '0;
    oc = 0;
    for (int k = 0; k < 60; k++) b[k] = blk[479-8*k -: 8];
    for (int g = 0; g < n; g += 3) begin
      rem = n - g;
      v = {b[g], (rem > 1) ? b[g+1] : 8'h00, (rem > 2) ? b[g+2] : 8'h00};
      for (int s = 0; s < 4; s++) begin
        if ((rem == 1 && s >= 2) || (rem == 2 && s == 3)) d[639-8*oc -: 8] = 8'h3D;
        else d[639-8*oc -: 8] = alpha[int'((v >> (18 - 6*s)) & 24'h3F)];
        oc++;
      end
    end
    nch = 7'(oc);
  endfunction

  function automatic logic [479:0] rnd_blk();
    logic [479:0] r;
    for (int w = 0; w < 15; w++) r[32*w +: 32] = $urandom();
    return r;
  endfunction

  // Core model: encodes all 60 bytes, valid only CORE_LAT cycles after start, garbage otherwise.
  initial begin
    logic [639:0] enc;
    logic [639:0] junk;
    logic [23:0]  v;
    int           cd;
    enc = '0;
    cd = 0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        starts_seen++;
        for (int g = 0; g < 20; g++) begin
          v = core_data[479-24*g -: 24];
          for (int s = 0; s < 4; s++) enc[639-32*g-8*s -: 8] = alpha[int'(v[23-6*s -: 6])];
        end
        cd = LAT + 1;
      end else if (cd > 0) begin
        cd--;
      end
      for (int w = 0; w < 20; w++) junk[32*w +: 32] = $urandom();
      core_result = (cd == 1) ? enc : junk;
    end
  end

  task automatic accept(input int g);
    exp_t e;
    int   n;
    n       = int'(req_nbytes[6*g +: 6]);
    e.id    = IDW'(g);
    e.t_acc = cyc;
    if (lit_on) begin
      e.data = lit_data;
      e.nch  = lit_nch;
      lit_on = 1'b0;
    end else begin
      b64_ref(req_data[480*g +: 480], n, e.data, e.nch);
    end
    e.lat = (n == 0) ? 1 : LAT + 2;
    if (n != 0) starts_exp++;
    exp_q.push_back(e);
    rr_m = (g + 1) % NREQ;
    accepted[g] = 1'b1;
  endtask

  // One cycle: predict the grant from the model, check it, record any accepted job.
  task automatic step();
    logic [NREQ-1:0] want;
    int g;
    @(negedge clk);
    want = '0;
    g = -1;
    if (rst_n && exp_q.size() == 0)
      for (int off = 0; off < NREQ; off++)
        if (g < 0 && req_valid[(rr_m + off) % NREQ]) g = (rr_m + off) % NREQ;
    if (g >= 0) want[g] = 1'b1;
    check("req_ready", req_ready, want);
    if (!rst_n) begin
      check("rst_core_start", core_start, 0);
      check("rst_core_data", core_data, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_nchars", rsp_nchars, 0);
    end
    if (g >= 0) accept(g);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        seen = 1'b0;
      end else if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_rsp: rsp_valid=1 id=%0d with no job outstanding", rsp_id);
        end else begin
          if (!seen) begin
            check("rsp_latency", cyc - exp_q[0].t_acc, exp_q[0].lat);
            seen = 1'b1;
          end
          check("rsp_id", rsp_id, exp_q[0].id);
          check("rsp_nchars", rsp_nchars, exp_q[0].nch);
          check("rsp_data", rsp_data, exp_q[0].data);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic load(input int i, input logic [479:0] blk, input int n);
    req_data[480*i +: 480] = blk;
    req_nbytes[6*i +: 6]   = 6'(n);
    req_valid[i]           = 1'b1;
  endtask

  task automatic set_lit(input logic [31:0] chars);
    lit_data = '0;
    lit_data[639 -: 32] = chars;
    lit_nch = 7'd4;
    lit_on = 1'b1;
  endtask

  task automatic run_job(input int i, input logic [479:0] blk, input int n);
    int k;
    load(i, blk, n);
    accepted[i] = 1'b0;
    k = 0;
    while (!accepted[i] && k < 40) begin
      step();
      k++;
    end
    if (!accepted[i]) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req %0d not granted in 40 cycles", i);
    end
    accepted[i] = 1'b0;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && k < 60) begin
      step();
      k++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic int rnd_n();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
  endfunction

  initial begin
    logic [479:0] b;
    for (int i = 0; i < NREQ; i++) accepted[i] = 1'b0;
    rst_n = 1'b0;
    req_data = '0;
    req_nbytes = '0;
    req_valid = '1;
    rsp_ready = 1'b0;
    step();
    step();
    req_valid = '0;
    rst_n = 1'b1;
    step();

    rsp_ready = 1'b1;
    b = rnd_blk(); b[479 -: 24] = 24'h4D616E; set_lit(32'h54574675); run_job(0, b, 3); drain();
    b = rnd_blk(); b[479 -: 8] = 8'h4D; set_lit(32'h54513D3D); run_job(1, b, 1); drain();
    b = rnd_blk(); b[479 -: 16] = 16'h4D61; set_lit(32'h5457453D); run_job(1, b, 2); drain();
    run_job(0, rnd_blk(), 60); drain();
    run_job(1, rnd_blk(), 63); drain();
    run_job(0, rnd_blk(), 0); drain();

    // Both requesters always pending: grants must alternate.
    load(0, rnd_blk(), rnd_n());
    load(1, rnd_blk(), rnd_n());
    for (int c = 0; c < 8 * (LAT + 3); c++) begin
      step();
      for (int i = 0; i < NREQ; i++)
        if (accepted[i]) begin
          accepted[i] = 1'b0;
          load(i, rnd_blk(), 1 + $urandom_range(0, 59));
        end
    end
    req_valid = '0;
    drain();

    // Consumer stall: response held, no new grant or launch.
    rsp_ready = 1'b0;
    run_job(0, rnd_blk(), 10);
    load(1, rnd_blk(), 20);
    repeat (LAT + 12) step();
    req_valid[1] = 1'b0;
    drain();

    // Reset while waiting on the core.
    run_job(1, rnd_blk(), 2);
    step();
    rst_n = 1'b0;
    exp_q.delete();
    rr_m = 0;
    step();
    step();
    rst_n = 1'b1;
    repeat (LAT + 4) step();
    load(1, rnd_blk(), 5);
    b = rnd_blk(); b[479 -: 24] = 24'h4D616E; set_lit(32'h54574675); run_job(0, b, 3);
    req_valid[1] = 1'b0;
    drain();

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (accepted[i] || !req_valid[i]) begin
          accepted[i] = 1'b0;
          if ($urandom_range(0, 3) != 0) load(i, rnd_blk(), rnd_n());
          else req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    drain();
    step();
    check("core_start_count", starts_seen, starts_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
